// File: rtl/cmd_link_pkg.sv
// Shared definitions for the command-bus host link: FSM state encoding and
// the number of bytes that make up one command or response word.
package cmd_link_pkg;

    typedef enum logic [1:0] {
        C_LINK_S_RX    = 2'd0,
        C_LINK_S_ISSUE = 2'd1,
        C_LINK_S_WAIT  = 2'd2,
        C_LINK_S_TX    = 2'd3
    } link_state_e;

    localparam int C_LINK_BYTES = 4;
    localparam logic [1:0] C_LINK_LAST_BYTE = 2'(C_LINK_BYTES - 1);

endpackage

// File: rtl/cmd_link.sv
// Host-side command bus initiator: gathers four rx bytes into a command word,
// strobes it to the decoders, samples the response and streams it out as four bytes.
module cmd_link
    import cmd_link_pkg::*;
#(
    parameter int RSP_WAIT       = 1,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        run,
    output logic [31:0] cmd,
    input  logic [31:0] rsp,
    output logic        busy,
    output logic        err_timeout,
    output logic [15:0] n_cmds
);

    localparam int WW = $clog2(RSP_WAIT + 1);
    localparam int IW = $clog2(TIMEOUT_CYCLES);

    link_state_e   state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [31:0]   asm_q, asm_d;
    logic [31:0]   cmd_q, cmd_d;
    logic [31:0]   shift_q, shift_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [15:0]   n_cmds_q, n_cmds_d;
    logic          err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= C_LINK_S_RX;
            cnt_q    <= '0;
            asm_q    <= '0;
            cmd_q    <= '0;
            shift_q  <= '0;
            wait_q   <= '0;
            idle_q   <= '0;
            n_cmds_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            asm_q    <= asm_d;
            cmd_q    <= cmd_d;
            shift_q  <= shift_d;
            wait_q   <= wait_d;
            idle_q   <= idle_d;
            n_cmds_q <= n_cmds_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        cmd_d    = cmd_q;
        shift_d  = shift_q;
        wait_d   = wait_q;
        idle_d   = idle_q;
        n_cmds_d = n_cmds_q;
        err_d    = 1'b0;

        case (state_q)
            C_LINK_S_RX: begin
                if (rx_valid) begin
                    asm_d  = {asm_q[23:0], rx_data};
                    idle_d = '0;
                    if (cnt_q == C_LINK_LAST_BYTE) begin
                        cnt_d   = '0;
                        cmd_d   = {asm_q[23:0], rx_data};
                        state_d = C_LINK_S_ISSUE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end else if (cnt_q != 2'd0) begin
                    // A stalled partial command is dropped so the next byte starts a fresh word.
                    if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
                        cnt_d  = '0;
                        asm_d  = '0;
                        idle_d = '0;
                        err_d  = 1'b1;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            C_LINK_S_ISSUE: begin
                wait_d   = WW'(RSP_WAIT);
                n_cmds_d = n_cmds_q + 16'd1;
                state_d  = C_LINK_S_WAIT;
            end
            C_LINK_S_WAIT: begin
                wait_d = wait_q - 1'b1;
                if (wait_q == WW'(1)) begin
                    shift_d = rsp;
                    state_d = C_LINK_S_TX;
                end
            end
            C_LINK_S_TX: begin
                if (tx_ready) begin
                    shift_d = {shift_q[23:0], 8'h00};
                    if (cnt_q == C_LINK_LAST_BYTE) begin
                        cnt_d   = '0;
                        state_d = C_LINK_S_RX;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = C_LINK_S_RX;
        endcase
    end

    // rx_ready is gated by rst so the source never sees a handshake while reset is held.
    assign rx_ready    = (state_q == C_LINK_S_RX) && !rst;
    assign tx_valid    = (state_q == C_LINK_S_TX);
    assign tx_data     = shift_q[31:24];
    assign run         = (state_q == C_LINK_S_ISSUE);
    assign cmd         = cmd_q;
    assign busy        = !((state_q == C_LINK_S_RX) && (cnt_q == 2'd0));
    assign err_timeout = err_q;
    assign n_cmds      = n_cmds_q;

endmodule
